// File: rtl/bus_watch_if.sv
// CPU bus bundle seen by the breakpoint watcher.
//   phi2 : CPU PHI2, already synchronised to the system clock
//   rw   : 1 = read, 0 = write
//   sync : opcode-fetch marker
//   addr : CPU address
//   din  : CPU data bus
// master drives the bus (CPU side / bench); slave observes it (bus_watch).
interface bus_watch_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              phi2;
   logic              rw;
   logic              sync;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;

   modport master (output phi2, rw, sync, addr, din);
   modport slave  (input  phi2, rw, sync, addr, din);
endinterface

// File: rtl/bus_watch.sv
// Bus watcher: breakpoint comparators, bus-cycle capture/counter and an NMI
// pulse generator with a post-pulse holdoff.
//   clk, rst_n      : system clock, async active-low reset
//   bus             : CPU bus (phi2/rw/sync/addr/din), slave modport
//   i_bp_en         : per-channel enable
//   i_bp_addr/mask  : per-channel pattern and compare mask (1 = compared)
//   i_bp_mode       : per-channel 00 any, 01 read, 10 write, 11 opcode fetch
//   i_step_req      : one-clk single-step NMI request
//   i_cnt_clr       : synchronous clear of the bus-cycle counter
//   o_nmi_n         : active-low NMI
//   o_hit/o_hit_vec : breakpoint pulse and the channels that matched
//   o_cap_*         : bus state captured at the last PHI2 falling edge
//   o_cycle_cnt     : completed bus cycles
//   o_overrun       : sticky, a trigger was dropped
//
// NMI FSM
//   state      | meaning
//   ST_IDLE    | nmi_n high, accepting triggers
//   ST_PULSE   | nmi_n low for PULSE_W clks
//   ST_HOLDOFF | nmi_n high for PULSE_W clks, triggers dropped
module bus_watch #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int CHANNELS = 4,
   parameter int PULSE_W  = 128,
   parameter int CNT_W    = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   bus_watch_if.slave                   bus,
   input  logic [CHANNELS-1:0]          i_bp_en,
   input  logic [CHANNELS*ADDR_W-1:0]   i_bp_addr,
   input  logic [CHANNELS*ADDR_W-1:0]   i_bp_mask,
   input  logic [2*CHANNELS-1:0]        i_bp_mode,
   input  logic                         i_step_req,
   input  logic                         i_cnt_clr,
   output logic                         o_nmi_n,
   output logic                         o_hit,
   output logic [CHANNELS-1:0]          o_hit_vec,
   output logic [ADDR_W-1:0]            o_cap_addr,
   output logic [DATA_W-1:0]            o_cap_data,
   output logic                         o_cap_rw,
   output logic                         o_cap_sync,
   output logic [CNT_W-1:0]             o_cycle_cnt,
   output logic                         o_overrun
);

   localparam int TMR_W = $clog2(PULSE_W);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PULSE_W - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLDOFF} nmi_state_t;

   nmi_state_t          r_state;
   logic [TMR_W-1:0]    r_tmr;
   logic                r_nmi_n;
   logic                r_overrun;
   logic                r_phi2_d;
   logic                r_hit;
   logic [CHANNELS-1:0] r_hit_vec;
   logic [ADDR_W-1:0]   r_cap_addr;
   logic [DATA_W-1:0]   r_cap_data;
   logic                r_cap_rw;
   logic                r_cap_sync;
   logic [CNT_W-1:0]    r_cycle_cnt;

   logic                w_cyc_end;
   logic                w_trig;
   logic                w_mode_ok;
   logic [CHANNELS-1:0] w_match;

   // History is {r_phi2_d, current phi2}; r_phi2_d resets low so a phi2
   // already high at release must be seen high before its fall counts.
   assign w_cyc_end = r_phi2_d & ~bus.phi2;
   assign w_trig    = r_hit | i_step_req;

   always_comb begin
      w_match   = '0;
      w_mode_ok = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         case (i_bp_mode[2*i +: 2])
            2'b00:   w_mode_ok = 1'b1;
            2'b01:   w_mode_ok = bus.rw;
            2'b10:   w_mode_ok = ~bus.rw;
            default: w_mode_ok = bus.rw & bus.sync;
         endcase
         w_match[i] = i_bp_en[i] & w_mode_ok &
            (((bus.addr ^ i_bp_addr[i*ADDR_W +: ADDR_W]) &
              i_bp_mask[i*ADDR_W +: ADDR_W]) == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phi2_d    <= 1'b0;
         r_hit       <= 1'b0;
         r_hit_vec   <= '0;
         r_cap_addr  <= '0;
         r_cap_data  <= '0;
         r_cap_rw    <= 1'b0;
         r_cap_sync  <= 1'b0;
         r_cycle_cnt <= '0;
      end else begin
         r_phi2_d <= bus.phi2;
         r_hit    <= w_cyc_end & (|w_match);
         if (w_cyc_end && (|w_match))
            r_hit_vec <= w_match;
         if (w_cyc_end) begin
            r_cap_addr <= bus.addr;
            r_cap_data <= bus.din;
            r_cap_rw   <= bus.rw;
            r_cap_sync <= bus.sync;
         end
         // Clear has priority over a coincident cycle end.
         if (i_cnt_clr)
            r_cycle_cnt <= '0;
         else if (w_cyc_end)
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_tmr     <= '0;
         r_nmi_n   <= 1'b1;
         r_overrun <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_trig) begin
                  r_state <= ST_PULSE;
                  r_nmi_n <= 1'b0;
                  r_tmr   <= TMR_LOAD;
               end
            end
            ST_PULSE: begin
               if (w_trig)
                  r_overrun <= 1'b1;
               if (r_tmr == '0) begin
                  r_state <= ST_HOLDOFF;
                  r_nmi_n <= 1'b1;
                  r_tmr   <= TMR_LOAD;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            ST_HOLDOFF: begin
               // A trigger on the exit clk is still dropped.
               if (w_trig)
                  r_overrun <= 1'b1;
               if (r_tmr == '0)
                  r_state <= ST_IDLE;
               else
                  r_tmr <= r_tmr - TMR_W'(1);
            end
            default: begin
               r_state <= ST_IDLE;
               r_nmi_n <= 1'b1;
            end
         endcase
      end
   end

   assign o_nmi_n     = r_nmi_n;
   assign o_hit       = r_hit;
   assign o_hit_vec   = r_hit_vec;
   assign o_cap_addr  = r_cap_addr;
   assign o_cap_data  = r_cap_data;
   assign o_cap_rw    = r_cap_rw;
   assign o_cap_sync  = r_cap_sync;
   assign o_cycle_cnt = r_cycle_cnt;
   assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_bus_watch.sv
// Bench for bus_watch: directed scenarios plus randomized bus cycles, every
// clk compared against a timestamp-based reference model.
module tb_bus_watch;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int CH = 4;
   localparam int PW = 128;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bus_watch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   logic [CH-1:0]    bp_en;
   logic [CH*AW-1:0] bp_addr, bp_mask;
   logic [2*CH-1:0]  bp_mode;
   logic             step_req, cnt_clr;
   logic             nmi_n, hit, cap_rw, cap_sync, overrun;
   logic [CH-1:0]    hit_vec;
   logic [AW-1:0]    cap_addr;
   logic [DW-1:0]    cap_data;
   logic [CW-1:0]    cycle_cnt;

   bus_watch #(.ADDR_W(AW), .DATA_W(DW), .CHANNELS(CH), .PULSE_W(PW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_bp_mask(bp_mask), .i_bp_mode(bp_mode),
      .i_step_req(step_req), .i_cnt_clr(cnt_clr),
      .o_nmi_n(nmi_n), .o_hit(hit), .o_hit_vec(hit_vec),
      .o_cap_addr(cap_addr), .o_cap_data(cap_data), .o_cap_rw(cap_rw),
      .o_cap_sync(cap_sync), .o_cycle_cnt(cycle_cnt), .o_overrun(overrun));

   int errors = 0;
   int checks = 0;

   // Reference model: edge index n, index of last accepted trigger.
   int            n = 0;
   int            last_acc = -100000;
   bit            m_hit, m_ovr, m_phi_prev;
   logic [CH-1:0] m_vec;
   logic [AW-1:0] m_caddr;
   logic [DW-1:0] m_cdata;
   bit            m_crw, m_csync;
   logic [CW-1:0] m_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic logic [CH-1:0] ref_match(input logic [AW-1:0] a, input bit r, input bit s);
      logic [CH-1:0] v;
      logic [AW-1:0] pa, pm;
      bit            mode_ok;
      v = '0;
      for (int c = 0; c < CH; c++) begin
         pa = bp_addr[c*AW +: AW];
         pm = bp_mask[c*AW +: AW];
         case (bp_mode[2*c +: 2])
            2'd0:    mode_ok = 1'b1;
            2'd1:    mode_ok = r;
            2'd2:    mode_ok = !r;
            default: mode_ok = r && s;
         endcase
         if (bp_en[c] && ((a & pm) == (pa & pm)) && mode_ok) v[c] = 1'b1;
      end
      return v;
   endfunction

   task automatic model_reset();
      last_acc = -100000;
      m_hit = 0; m_ovr = 0; m_phi_prev = 0; m_vec = '0;
      m_caddr = '0; m_cdata = '0; m_crw = 0; m_csync = 0; m_cnt = '0;
   endtask

   task automatic check_all();
      bit exp_nmi;
      exp_nmi = !(n >= last_acc && n <= last_acc + PW - 1);
      chk("nmi_n", nmi_n, exp_nmi);
      chk("hit", hit, m_hit);
      chk("hit_vec", hit_vec, m_vec);
      chk("cap_addr", cap_addr, m_caddr);
      chk("cap_data", cap_data, m_cdata);
      chk("cap_rw", cap_rw, m_crw);
      chk("cap_sync", cap_sync, m_csync);
      chk("cycle_cnt", cycle_cnt, m_cnt);
      chk("overrun", overrun, m_ovr);
   endtask

   task automatic tick();
      bit            trig, ce, r, s;
      logic [CH-1:0] mv;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      trig = m_hit || step_req;
      ce   = m_phi_prev && !bus.phi2;
      a = bus.addr; d = bus.din; r = bus.rw; s = bus.sync;
      mv = ref_match(a, r, s);
      @(posedge clk); #1;
      n++;
      if (trig) begin
         if (n >= last_acc + 2*PW + 1) last_acc = n;
         else m_ovr = 1;
      end
      m_hit = ce && (mv != '0);
      if (m_hit) m_vec = mv;
      if (ce) begin
         m_caddr = a; m_cdata = d; m_crw = r; m_csync = s;
         m_cnt = m_cnt + 1'b1;
      end
      if (cnt_clr) m_cnt = '0;
      m_phi_prev = bus.phi2;
      check_all();
   endtask

   task automatic idle(input int k);
      repeat (k) tick();
   endtask

   task automatic step();
      step_req = 1'b1; tick(); step_req = 1'b0;
   endtask

   task automatic setch(input int c, input bit en, input logic [AW-1:0] a,
                        input logic [AW-1:0] m, input logic [1:0] md);
      bp_en[c] = en;
      bp_addr[c*AW +: AW] = a;
      bp_mask[c*AW +: AW] = m;
      bp_mode[2*c +: 2] = md;
   endtask

   // Returns just after the cycle-end edge; garbage on addr/din while phi2 is high.
   task automatic bus_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit r,
                            input bit s, input int nlow, input int nhigh, input bit clr);
      bus.addr = a; bus.din = d; bus.rw = r; bus.sync = s; bus.phi2 = 1'b0;
      idle(nlow);
      bus.phi2 = 1'b1;
      for (int i = 0; i < nhigh; i++) begin
         if (i < nhigh - 1) begin
            bus.addr = AW'($urandom); bus.din = DW'($urandom);
            bus.rw = 1'($urandom); bus.sync = 1'($urandom);
         end else begin
            bus.addr = a; bus.din = d; bus.rw = r; bus.sync = s;
         end
         tick();
      end
      bus.phi2 = 1'b0; cnt_clr = clr;
      tick();
      cnt_clr = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_nmi_n"}, nmi_n, 1'b1);
      chk({tag, "_hit"}, hit, 1'b0);
      chk({tag, "_hit_vec"}, hit_vec, '0);
      chk({tag, "_cap_addr"}, cap_addr, '0);
      chk({tag, "_cap_data"}, cap_data, '0);
      chk({tag, "_cap_rw"}, cap_rw, 1'b0);
      chk({tag, "_cap_sync"}, cap_sync, 1'b0);
      chk({tag, "_cycle_cnt"}, cycle_cnt, '0);
      chk({tag, "_overrun"}, overrun, 1'b0);
   endtask

   logic [AW-1:0] pool [4];
   logic [AW-1:0] ra;
   int            t0;

   initial begin
      bus.phi2 = 1'b0; bus.rw = 1'b1; bus.sync = 1'b0; bus.addr = '0; bus.din = '0;
      bp_en = '0; bp_addr = '0; bp_mask = '0; bp_mode = '0;
      step_req = 1'b0; cnt_clr = 1'b0;
      model_reset();
      repeat (2) begin @(posedge clk); #1; n++; end
      reset_checks("por");
      rst_n = 1'b1;
      idle(3);

      // Single-channel exact match, any mode.
      setch(0, 1, 16'hFFFA, 16'hFFFF, 2'b00);
      bus_cycle(16'hFFFA, 8'h5A, 1, 0, 2, 2, 0);
      chk("d39_hit", hit, 1'b1);
      chk("d39_vec", hit_vec, 4'b0001);
      tick();
      chk("d39_nmi_low", nmi_n, 1'b0);
      idle(300);

      // Opcode-fetch mode with upper-byte mask.
      setch(0, 0, 16'hFFFA, 16'hFFFF, 2'b00);
      setch(1, 1, 16'h8000, 16'hFF00, 2'b11);
      bus_cycle(16'h8042, 8'h11, 1, 0, 2, 3, 0);
      chk("d40_nohit", hit, 1'b0);
      bus_cycle(16'h8042, 8'h22, 1, 1, 2, 3, 0);
      chk("d40_hit", hit, 1'b1);
      chk("d40_vec", hit_vec, 4'b0010);
      chk("d40_cap_addr", cap_addr, 16'h8042);
      chk("d40_cap_sync", cap_sync, 1'b1);
      tick();

      // Steps during PULSE and HOLDOFF are dropped.
      idle(10);
      step();
      chk("d41_ovr_pulse", overrun, 1'b1);
      idle(130);
      step();
      chk("d41_nmi_hold", nmi_n, 1'b1);
      idle(300);
      step();
      chk("d41_new_pulse", nmi_n, 1'b0);
      idle(300);

      // Two channels on one write: a single pulse.
      setch(1, 0, 16'h8000, 16'hFF00, 2'b11);
      setch(0, 1, 16'h1234, 16'hFFFF, 2'b10);
      setch(2, 1, 16'h1234, 16'hFFFF, 2'b00);
      bus_cycle(16'h1234, 8'hAB, 0, 0, 1, 2, 0);
      chk("d42_vec", hit_vec, 4'b0101);
      chk("d42_cap_rw", cap_rw, 1'b0);
      idle(300);

      // Counter wrap and clear priority.
      bp_en = '0;
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      for (int i = 0; i < 17; i++) bus_cycle(AW'(i), DW'(i), 1, 0, 1, 1, 0);
      chk("d43_wrap", cycle_cnt, 4'd1);
      bus_cycle(16'h0042, 8'h00, 1, 0, 1, 1, 1);
      chk("d43_clr_wins", cycle_cnt, 4'd0);
      idle(2);

      // Reset at clk 50 of a pulse, with phi2 high through reset.
      step();
      idle(50);
      chk("d44_nmi_before", nmi_n, 1'b0);
      bus.phi2 = 1'b1;
      #3 rst_n = 1'b0;
      #1 reset_checks("d44_async");
      model_reset();
      repeat (2) begin @(posedge clk); #1; n++; end
      rst_n = 1'b1;
      bus.phi2 = 1'b0;
      idle(300);
      chk("d44_no_pulse", nmi_n, 1'b1);

      // Exit clk of HOLDOFF drops a trigger; the next clk accepts one.
      step();
      t0 = n;
      idle(255);
      step();
      chk("exit_drop_ovr", overrun, 1'b1);
      chk("exit_drop_nmi", nmi_n, 1'b1);
      step();
      chk("exit_next_ok", nmi_n, 1'b0);
      chk("exit_edge", n - t0, 257);
      idle(300);

      // Randomized bus cycles against the model.
      pool[0] = 16'h1234; pool[1] = 16'h8000; pool[2] = 16'hFFFA; pool[3] = 16'h0F0F;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            for (int c = 0; c < CH; c++)
               setch(c, 1'($urandom), pool[$urandom_range(0, 3)],
                     ($urandom_range(0, 1) == 0) ? 16'hFFFF : AW'($urandom),
                     2'($urandom));
         end
         ra = pool[$urandom_range(0, 3)] ^ (AW'($urandom) & 16'h00FF);
         bus_cycle(ra, DW'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(1, 3), $urandom_range(1, 3),
                   ($urandom_range(0, 5) == 0));
         if ($urandom_range(0, 4) == 0) step();
         idle($urandom_range(0, 300));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bus_watch.md
BUS_WATCH -- requirements
Module: bus_watch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, CPU address width.
REQ-002 SHALL have parameter DATA_W, default 8, CPU data width.
REQ-003 SHALL have parameter CHANNELS, default 4, number of breakpoint comparators (1..8).
REQ-004 SHALL have parameter PULSE_W, default 128, NMI low-pulse width and post-pulse holdoff in clk cycles (>=2).
REQ-005 SHALL have parameter CNT_W, default 32, bus-cycle counter width.
REQ-006 clk  in  1  system clock (CLK25MHZ domain); sole clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 phi2  in  1  CPU PHI2, already synchronised to clk.
REQ-009 rw, sync  in  1 each  CPU RW (1=read) and SYNC, synchronised.
REQ-010 addr  in  ADDR_W  synchronised CPU address.
REQ-011 din  in  DATA_W  synchronised CPU data bus.
REQ-012 bp_en  in  CHANNELS  per-channel enable.
REQ-013 bp_addr, bp_mask  in  CHANNELS*ADDR_W  per-channel pattern and compare mask (1=bit compared); channel i at [i*ADDR_W +: ADDR_W].
REQ-014 bp_mode  in  2*CHANNELS  per channel: 00 any, 01 read, 10 write, 11 opcode fetch (rw=1 and sync=1).
REQ-015 step_req  in  1  one-clk pulse requesting an NMI (single step).
REQ-016 cnt_clr  in  1  synchronous clear of cycle counter.
REQ-017 nmi_n  out  1  active-low NMI to CPU.
REQ-018 hit  out  1  one-clk pulse on a breakpoint match.
REQ-019 hit_vec  out  CHANNELS  registered matching channels of last hit.
REQ-020 cap_addr / cap_data / cap_rw / cap_sync  out  ADDR_W / DATA_W / 1 / 1  bus state captured at last PHI2 falling edge.
REQ-021 cycle_cnt  out  CNT_W  number of completed bus cycles.
REQ-022 overrun  out  1  sticky: a trigger was dropped.

Function
REQ-023 Bus-cycle end SHALL be detected as phi2 1 in previous clk, 0 in current clk (falling edge, 2-bit history register).
REQ-024 On cycle end, addr/din/rw/sync SHALL be registered into cap_* (1 clk latency) and cycle_cnt incremented, wrapping from all-ones to 0.
REQ-025 cnt_clr SHALL zero cycle_cnt; if coincident with a cycle end, clear wins.
REQ-026 Channel i matches when bp_en[i] and ((addr ^ bp_addr_i) & bp_mask_i)==0 and mode condition holds, evaluated on the cycle-end clk using the inputs sampled then.
REQ-027 hit SHALL assert exactly one clk after a matching cycle end; hit_vec SHALL load the full match vector at that time and hold until the next hit.
REQ-028 Trigger = hit pulse OR step_req; simultaneous sources form one trigger.
REQ-029 NMI FSM states: IDLE (nmi_n=1), PULSE (nmi_n=0), HOLDOFF (nmi_n=1).
REQ-030 IDLE -> PULSE on trigger; nmi_n SHALL fall the clk after the trigger.
REQ-031 PULSE SHALL last exactly PULSE_W clks, then -> HOLDOFF.
REQ-032 HOLDOFF SHALL last exactly PULSE_W clks, then -> IDLE, guaranteeing a clean high before the next edge.
REQ-033 A trigger in PULSE or HOLDOFF SHALL be dropped and set overrun; overrun clears only on reset.
REQ-034 A trigger in the same clk as HOLDOFF->IDLE exit SHALL be dropped (overrun set).
REQ-035 Bus signal changes while phi2 is high SHALL have no effect on matching or capture.

Reset
REQ-036 rst_n low SHALL immediately force nmi_n=1, hit=0, hit_vec=0, cap_*=0, cycle_cnt=0, overrun=0, FSM=IDLE, phi2 history=00.
REQ-037 Reset asserted mid-PULSE SHALL release nmi_n high at once; no pulse resumes after reset.
REQ-038 A phi2 already high at reset release SHALL NOT count as a cycle end until it has been seen high then low.

Verification
REQ-039 Ch0 en, addr 0xFFFA mask 0xFFFF mode 00; read cycle at 0xFFFA -> hit 1 clk after fall, hit_vec=0001, nmi_n low 128 clks.
REQ-040 Ch1 mode 11 addr 0x8000 mask 0xFF00; read 0x8042 sync=0 -> no hit; same with sync=1 -> hit_vec=0010, cap_addr=0x8042, cap_sync=1.
REQ-041 step_req during PULSE and during HOLDOFF -> no extra pulse, overrun=1; step_req after 256 clks -> new 128-clk pulse.
REQ-042 Ch0 and ch2 both match 0x1234 write -> single pulse, hit_vec=0101, cap_rw=0.
REQ-043 CNT_W=4: 17 bus cycles -> cycle_cnt=1; cnt_clr coincident with a cycle end -> 0.
REQ-044 rst_n low at clk 50 of a pulse -> nmi_n=1 immediately, all outputs zero, no pulse after release.
